// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for the 32x32 register file: arbitrates pipeline writeback (A)
// against buffered long-latency results (B) and tracks pending long-op destinations.
module regfile_wr_sched #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_we,
    input  logic [ADDR_W-1:0]    a_waddr,
    input  logic [DATA_W-1:0]    a_wdata,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [ADDR_W-1:0]    b_waddr,
    input  logic [DATA_W-1:0]    b_wdata,
    input  logic                 iss_valid,
    input  logic [ADDR_W-1:0]    iss_waddr,
    output logic [2**ADDR_W-1:0] busy_o,
    output logic                 stall_o,
    output logic                 err_o,
    output logic                 we,
    output logic [ADDR_W-1:0]    waddr,
    output logic [DATA_W-1:0]    wdata
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int AGE_W = $clog2(MAX_WAIT + 1);
    localparam int NREG  = 2**ADDR_W;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count, count_next;
    logic [AGE_W-1:0]  age, age_next;
    logic              full, empty, push, pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [NREG-1:0]   set_mask, clr_mask;

    // Readiness depends only on the registered count, so a same-cycle pop never frees a slot.
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign b_ready   = !full;
    assign push      = b_valid && !full;
    assign pop       = !a_we && !empty;
    assign head_addr = fifo_addr[rd_ptr];
    assign head_data = fifo_data[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase

        age_next = '0;
        if (!empty && !pop) begin
            age_next = (age == AGE_W'(MAX_WAIT)) ? age : age + AGE_W'(1);
        end

        set_mask = '0;
        if (iss_valid && (iss_waddr != '0)) begin
            set_mask[iss_waddr] = 1'b1;
        end

        clr_mask = '0;
        if (pop) begin
            clr_mask[head_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= b_waddr;
            fifo_data[wr_ptr] <= b_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            age     <= '0;
            busy_o  <= '0;
            stall_o <= 1'b0;
            err_o   <= 1'b0;
            we      <= 1'b0;
            waddr   <= '0;
            wdata   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            age   <= age_next;

            we <= 1'b0;
            if (a_we) begin
                we    <= (a_waddr != '0);
                waddr <= a_waddr;
                wdata <= a_wdata;
            end else if (pop) begin
                we    <= (head_addr != '0);
                waddr <= head_addr;
                wdata <= head_data;
            end

            // Applying the set after the clear lets a fresh issue win over a retiring result.
            busy_o  <= (busy_o & ~clr_mask) | set_mask;
            stall_o <= (age_next == AGE_W'(MAX_WAIT)) && (count_next != '0);
            if (a_we && stall_o) err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench for regfile_wr_sched: queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_regfile_wr_sched;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int DEPTH = 2;
    localparam int MAXW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_we = 1'b0;
    logic [AW-1:0] a_waddr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          b_valid = 1'b0;
    logic          b_ready;
    logic [AW-1:0] b_waddr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          iss_valid = 1'b0;
    logic [AW-1:0] iss_waddr = '0;
    logic [31:0]   busy_o;
    logic          stall_o, err_o, we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    int tests = 0;
    int fails = 0;
    bit en = 1'b0;

    regfile_wr_sched #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .a_we(a_we), .a_waddr(a_waddr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_waddr(b_waddr), .b_wdata(b_wdata),
        .iss_valid(iss_valid), .iss_waddr(iss_waddr),
        .busy_o(busy_o), .stall_o(stall_o), .err_o(err_o),
        .we(we), .waddr(waddr), .wdata(wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending results and a per-register pending flag.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          mq[$];
    logic          m_we = 1'b0;
    logic [AW-1:0] m_waddr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [31:0]   m_busy = '0;
    logic          m_stall = 1'b0;
    logic          m_err = 1'b0;
    int            m_age = 0;

    always @(posedge clk) begin : model
        int sz, na;
        bit popped, pushed;
        logic [31:0] nb;
        ent_t h;
        if (rst) begin
            mq.delete();
            m_age   <= 0;
            m_we    <= 1'b0;
            m_waddr <= '0;
            m_wdata <= '0;
            m_busy  <= '0;
            m_stall <= 1'b0;
            m_err   <= 1'b0;
        end else begin
            sz = mq.size();
            popped = !a_we && (sz > 0);
            pushed = b_valid && (sz < DEPTH);
            nb = m_busy;
            if (a_we && m_stall) m_err <= 1'b1;
            if (a_we) begin
                m_we <= (a_waddr != 0);
                m_waddr <= a_waddr;
                m_wdata <= a_wdata;
            end else if (popped) begin
                h = mq.pop_front();
                m_we <= (h.addr != 0);
                m_waddr <= h.addr;
                m_wdata <= h.data;
                nb[h.addr] = 1'b0;
            end else begin
                m_we <= 1'b0;
            end
            if (iss_valid && iss_waddr != 0) nb[iss_waddr] = 1'b1;
            m_busy <= nb;
            if (pushed) mq.push_back('{addr: b_waddr, data: b_wdata});
            na = (sz > 0 && !popped) ? ((m_age < MAXW) ? m_age + 1 : MAXW) : 0;
            m_age <= na;
            m_stall <= (na == MAXW) && (mq.size() > 0);
        end
    end

    always @(negedge clk) begin
        if (en) begin
            chk("m_we", 64'(we), 64'(m_we));
            chk("m_waddr", 64'(waddr), 64'(m_waddr));
            chk("m_wdata", 64'(wdata), 64'(m_wdata));
            chk("m_busy", 64'(busy_o), 64'(m_busy));
            chk("m_stall", 64'(stall_o), 64'(m_stall));
            chk("m_err", 64'(err_o), 64'(m_err));
            chk("m_bready", 64'(b_ready), 64'(mq.size() < DEPTH));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        en = 1'b1;

        // Reset then idle
        @(negedge clk);
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_bready", 64'(b_ready), 64'd1);
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);

        // A only
        a_we = 1'b1; a_waddr = 5'd3; a_wdata = 32'h1234;
        @(negedge clk);
        chk("a_we", 64'(we), 64'd1);
        chk("a_waddr", 64'(waddr), 64'd3);
        chk("a_wdata", 64'(wdata), 64'h1234);
        a_waddr = 5'd0; a_wdata = 32'h5555;
        @(negedge clk);
        chk("a_r0_we", 64'(we), 64'd0);
        a_we = 1'b0;

        // Issue and complete a long op
        iss_valid = 1'b1; iss_waddr = 5'd5;
        @(negedge clk);
        iss_valid = 1'b0;
        chk("iss_busy5", 64'(busy_o[5]), 64'd1);
        b_valid = 1'b1; b_waddr = 5'd5; b_wdata = 32'hBEEF;
        @(negedge clk);
        b_valid = 1'b0;
        chk("b_pending_busy5", 64'(busy_o[5]), 64'd1);
        @(negedge clk);
        chk("b_we", 64'(we), 64'd1);
        chk("b_waddr", 64'(waddr), 64'd5);
        chk("b_wdata", 64'(wdata), 64'hBEEF);
        chk("b_busy5_clr", 64'(busy_o[5]), 64'd0);

        // Fill and stall
        a_we = 1'b1; a_waddr = 5'd9; a_wdata = 32'h1;
        b_valid = 1'b1; b_waddr = 5'd10; b_wdata = 32'hA0A0;
        @(negedge clk);
        b_waddr = 5'd11; b_wdata = 32'hB1B1;
        @(negedge clk);
        b_valid = 1'b0;
        chk("full_bready", 64'(b_ready), 64'd0);
        repeat (2) @(negedge clk);
        chk("stall_early", 64'(stall_o), 64'd0);
        @(negedge clk);
        chk("stall_rise", 64'(stall_o), 64'd1);
        chk("stall_no_err", 64'(err_o), 64'd0);
        a_we = 1'b0;
        @(negedge clk);
        chk("drain1_we", 64'(we), 64'd1);
        chk("drain1_addr", 64'(waddr), 64'd10);
        chk("drain1_data", 64'(wdata), 64'hA0A0);
        chk("drain1_stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        chk("drain2_addr", 64'(waddr), 64'd11);
        chk("drain2_data", 64'(wdata), 64'hB1B1);
        @(negedge clk);
        chk("drain_idle_we", 64'(we), 64'd0);

        // Contract violation and set/clear collision on reg 7
        iss_valid = 1'b1; iss_waddr = 5'd7;
        a_we = 1'b1; a_waddr = 5'd1; a_wdata = 32'h11;
        b_valid = 1'b1; b_waddr = 5'd7; b_wdata = 32'h7777;
        @(negedge clk);
        iss_valid = 1'b0; b_valid = 1'b0;
        for (int i = 0; i < 10 && !stall_o; i++) @(negedge clk);
        chk("viol_stall", 64'(stall_o), 64'd1);
        a_waddr = 5'd12; a_wdata = 32'hC;
        @(negedge clk);
        chk("viol_we", 64'(we), 64'd1);
        chk("viol_waddr", 64'(waddr), 64'd12);
        chk("viol_err", 64'(err_o), 64'd1);
        a_we = 1'b0;
        iss_valid = 1'b1; iss_waddr = 5'd7;
        @(negedge clk);
        iss_valid = 1'b0;
        chk("coll_waddr", 64'(waddr), 64'd7);
        chk("coll_wdata", 64'(wdata), 64'h7777);
        chk("coll_busy7", 64'(busy_o[7]), 64'd1);

        // B result to reg 0 is popped but not written
        b_valid = 1'b1; b_waddr = 5'd0; b_wdata = 32'hDEAD;
        @(negedge clk);
        b_valid = 1'b0;
        @(negedge clk);
        chk("b_r0_we", 64'(we), 64'd0);

        // Full FIFO refuses a push even when popping the same cycle
        a_we = 1'b1; a_waddr = 5'd2; a_wdata = 32'h22;
        b_valid = 1'b1; b_waddr = 5'd3; b_wdata = 32'h31;
        @(negedge clk);
        b_waddr = 5'd4; b_wdata = 32'h41;
        @(negedge clk);
        a_we = 1'b0;
        b_waddr = 5'd6; b_wdata = 32'h61;
        @(negedge clk);
        b_valid = 1'b0;
        chk("fullpop_addr1", 64'(waddr), 64'd3);
        @(negedge clk);
        chk("fullpop_addr2", 64'(waddr), 64'd4);
        @(negedge clk);
        chk("fullpop_nopush", 64'(we), 64'd0);
        chk("err_sticky", 64'(err_o), 64'd1);

        // Reset mid-operation
        a_we = 1'b1; a_waddr = 5'd13; a_wdata = 32'hD;
        b_valid = 1'b1; b_waddr = 5'd8; b_wdata = 32'h88;
        iss_valid = 1'b1; iss_waddr = 5'd9;
        @(negedge clk);
        a_we = 1'b0; iss_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; b_valid = 1'b0;
        chk("mrst_we", 64'(we), 64'd0);
        chk("mrst_busy", 64'(busy_o), 64'd0);
        chk("mrst_bready", 64'(b_ready), 64'd1);
        chk("mrst_err", 64'(err_o), 64'd0);
        chk("mrst_waddr", 64'(waddr), 64'd0);
        @(negedge clk);
        chk("mrst_nowrite", 64'(we), 64'd0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
